// File: rtl/veririsc_sequencer.sv
// Self-timed VeriRISC sequencer: 8-phase fetch/execute counter, HLT/resume latch,
// optional memory wait-state stall with timeout (enabled by defining SEQ_MEM_WAIT_EN).
module veririsc_sequencer #(
  parameter int OPCODE_W   = 3,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zero,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_rdy,
  input  logic                resume,
  output logic [2:0]          phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                ld_pc,
  output logic                data_e,
  output logic                halted,
  output logic                bus_err
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0] state_p0;
  logic [2:0] phase_p0;
  logic       ext_op;
  logic [2:0] op_lo;
  logic       is_hlt, is_skz, is_sto, is_jmp, is_alu;
  logic       running;
  logic       stall;

  // Opcodes with any bit above the base three set form the extended-ALU class.
  generate
    if (OPCODE_W > 3) begin : g_ext
      assign ext_op = |opcode[OPCODE_W-1:3];
    end else begin : g_no_ext
      assign ext_op = 1'b0;
    end
  endgenerate

  assign op_lo   = opcode[2:0];
  assign is_hlt  = !ext_op && (op_lo == 3'd0);
  assign is_skz  = !ext_op && (op_lo == 3'd1);
  assign is_sto  = !ext_op && (op_lo == 3'd6);
  assign is_jmp  = !ext_op && (op_lo == 3'd7);
  assign is_alu  = ext_op || ((op_lo >= 3'd2) && (op_lo <= 3'd5));
  assign running = (state_p0 == ST_RUN);

`ifdef SEQ_MEM_WAIT_EN
  logic [7:0] wait_p0;
  logic       bus_err_p0;
  logic       stall_pt;
  logic       timeout;

  assign stall_pt = running && ((phase_p0 == 3'd1) || ((phase_p0 == 3'd5) && is_alu));
  // The last permitted wait cycle becomes the forced advance itself.
  assign timeout  = stall_pt && !mem_rdy && (wait_p0 >= 8'(WAIT_LIMIT - 1));
  assign stall    = stall_pt && !mem_rdy && !timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_p0    <= 8'd0;
      bus_err_p0 <= 1'b0;
    end else begin
      wait_p0    <= stall ? (wait_p0 + 8'd1) : 8'd0;
      bus_err_p0 <= timeout;
    end
  end

  assign bus_err = bus_err_p0;
`else
  logic       unused_mem_rdy;
  logic [7:0] unused_wait_limit;

  assign unused_mem_rdy    = mem_rdy;
  assign unused_wait_limit = 8'(WAIT_LIMIT);
  assign stall             = 1'b0;
  assign bus_err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_RUN;
      phase_p0 <= 3'd0;
    end else if (state_p0 == ST_RUN) begin
      if ((phase_p0 == 3'd4) && is_hlt) begin
        state_p0 <= ST_HALTED;
      end else if (!stall) begin
        phase_p0 <= phase_p0 + 3'd1;
      end
    end else if (resume) begin
      // Resume re-enters after the phase-4 PC increment already done before halting.
      state_p0 <= ST_RUN;
      phase_p0 <= 3'd5;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    if (running) begin
      case (phase_p0)
        3'd0: sel = 1'b1;
        3'd1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: begin
          halt   = is_hlt;
          inc_pc = 1'b1;
        end
        3'd5: rd = is_alu;
        3'd6: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        default: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
      endcase
    end
  end

  assign phase  = phase_p0;
  assign halted = (state_p0 == ST_HALTED);

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Bench for veririsc_sequencer: directed literal checks plus randomized run
// against a behavioural phase/halt/wait model.
module tb_veririsc_sequencer;

  localparam int OPW   = 4;
  localparam int WLIM  = 4;
`ifdef SEQ_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           zero = 1'b0;
  logic [OPW-1:0] opcode = 4'd2;
  logic           mem_rdy = 1'b1;
  logic           resume = 1'b0;
  logic [2:0]     phase;
  logic           sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
  logic           halted, bus_err;
  logic [8:0]     strb;

  int  n_cmp = 0;
  int  n_mis = 0;
  bit  chk_en = 1'b0;

  // Behavioural model state
  int  m_phase = 0;
  bit  m_halted = 1'b0;
  int  m_wait = 0;
  bit  m_berr = 1'b0;

  veririsc_sequencer #(.OPCODE_W(OPW), .WAIT_LIMIT(WLIM)) dut (
    .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .mem_rdy(mem_rdy),
    .resume(resume), .phase(phase), .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .halt(halt), .inc_pc(inc_pc), .ld_ac(ld_ac), .wr(wr), .ld_pc(ld_pc),
    .data_e(data_e), .halted(halted), .bus_err(bus_err)
  );

  assign strb = {sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_alu(input int op);
    return (op >= 2 && op <= 5) || (op >= 8);
  endfunction

  // Strobe table {sel,rd,ld_ir,halt,inc_pc,ld_ac,wr,ld_pc,data_e}
  function automatic logic [8:0] exp_strb(input int ph, input bit hl, input int op, input bit z);
    logic [8:0] v;
    v = '0;
    if (hl) return v;
    case (ph)
      0: v[8] = 1'b1;
      1: begin v[8] = 1'b1; v[7] = 1'b1; end
      2, 3: v[8:6] = 3'b111;
      4: begin v[5] = (op == 0); v[4] = 1'b1; end
      5: v[7] = is_alu(op);
      6: begin v[7] = is_alu(op); v[4] = (op == 1) && z; v[1] = (op == 7); v[0] = (op == 6); end
      default: begin
        v[7] = is_alu(op); v[3] = is_alu(op); v[1] = (op == 7);
        v[2] = (op == 6); v[0] = (op == 6);
      end
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_halted = 1'b0; m_wait = 0; m_berr = 1'b0;
    end else if (m_halted) begin
      m_berr = 1'b0;
      if (resume) begin
        m_halted = 1'b0;
        m_phase = 5;
      end
    end else begin
      m_berr = 1'b0;
      if (m_phase == 4 && int'(opcode) == 0) begin
        m_halted = 1'b1;
      end else if (WAIT_EN && !mem_rdy &&
                   (m_phase == 1 || (m_phase == 5 && is_alu(int'(opcode))))) begin
        m_wait = m_wait + 1;
        if (m_wait >= WLIM) begin
          m_phase = (m_phase + 1) % 8;
          m_wait = 0;
          m_berr = 1'b1;
        end
      end else begin
        m_phase = (m_phase + 1) % 8;
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model phase", 32'(phase), 32'(m_phase));
      check("model strobes", 32'(strb), 32'(exp_strb(m_phase, m_halted, int'(opcode), zero)));
      check("model halted", 32'(halted), 32'(m_halted));
      check("model bus_err", 32'(bus_err), 32'(m_berr));
    end
  end

  task automatic run_to_phase(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (phase !== 3'(p) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("run_to_phase timeout", 32'(phase), 32'(p));
  endtask

  typedef struct { int op; bit z; logic [8:0] s6; logic [8:0] s7; } exec_vec_t;

  initial begin
    exec_vec_t vt[5];
    vt[0] = '{1, 1'b1, 9'b000010000, 9'b000000000};
    vt[1] = '{1, 1'b0, 9'b000000000, 9'b000000000};
    vt[2] = '{6, 1'b0, 9'b000000001, 9'b000000101};
    vt[3] = '{7, 1'b0, 9'b000000010, 9'b000000010};
    vt[4] = '{9, 1'b0, 9'b010000000, 9'b010001000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset phase", 32'(phase), 32'd0);
    check("reset strobes", 32'(strb), 32'b100000000);
    check("reset halted", 32'(halted), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // Free run with ADD
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("add phase seq", 32'(phase), 32'((i + 1) % 8));
      check("add inc_pc only ph4", 32'(inc_pc), 32'(phase == 3'd4));
      if (phase == 3'd7) check("add ph7 strobes", 32'(strb), 32'b010001000);
    end

    // Execute-phase strobes per opcode
    for (int k = 0; k < 5; k++) begin
      run_to_phase(0);
      #1 opcode = 4'(vt[k].op); zero = vt[k].z;
      run_to_phase(6);
      check("exec ph6 strobes", 32'(strb), 32'(vt[k].s6));
      @(negedge clk);
      check("exec ph7 strobes", 32'(strb), 32'(vt[k].s7));
    end
    #1 opcode = 4'd2; zero = 1'b0;

    // HLT, hold, resume held high
    run_to_phase(0);
    #1 opcode = 4'd0;
    run_to_phase(4);
    check("hlt ph4 strobes", 32'(strb), 32'b000110000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halted flag", 32'(halted), 32'd1);
      check("halted phase", 32'(phase), 32'd4);
      check("halted strobes", 32'(strb), 32'd0);
    end
    #1 resume = 1'b1; opcode = 4'd2;
    @(negedge clk);
    check("resume phase", 32'(phase), 32'd5);
    check("resume halted", 32'(halted), 32'd0);
    check("resume no inc_pc", 32'(inc_pc), 32'd0);
    @(negedge clk);
    check("resume held ph6", 32'(phase), 32'd6);
    @(negedge clk);
    check("resume held ph7", 32'(phase), 32'd7);
    #1 resume = 1'b0;

    // HLT after resume halts again
    run_to_phase(0);
    #1 opcode = 4'd0;
    run_to_phase(4);
    @(negedge clk);
    check("rehalt", 32'(halted), 32'd1);
    #1 resume = 1'b1; opcode = 4'd2;
    @(negedge clk);
    #1 resume = 1'b0;

`ifdef SEQ_MEM_WAIT_EN
    // Three wait cycles at phase 1
    run_to_phase(1);
    #1 mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall ph1 phase", 32'(phase), 32'd1);
      check("stall ph1 strobes", 32'(strb), 32'b110000000);
    end
    #1 mem_rdy = 1'b1;
    @(negedge clk);
    check("stall ph1 release", 32'(phase), 32'd2);
    check("stall ph1 no bus_err", 32'(bus_err), 32'd0);

    // Timeout at phase 5 with LDA
    run_to_phase(0);
    #1 opcode = 4'd5;
    run_to_phase(5);
    #1 mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("timeout hold ph5", 32'(phase), 32'd5);
      check("timeout no early bus_err", 32'(bus_err), 32'd0);
    end
    @(negedge clk);
    check("timeout advance", 32'(phase), 32'd6);
    check("timeout bus_err", 32'(bus_err), 32'd1);
    #1 mem_rdy = 1'b1;
    @(negedge clk);
    check("timeout bus_err pulse", 32'(bus_err), 32'd0);
`endif

    // Reset while in phase 5 (stalled when waits are enabled)
    run_to_phase(0);
    #1 opcode = 4'd5;
    run_to_phase(5);
    #1 mem_rdy = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst ph5 phase", 32'(phase), 32'd0);
    check("rst ph5 strobes", 32'(strb), 32'b100000000);
    #1 rst = 1'b0; mem_rdy = 1'b1; opcode = 4'd0;

    // Reset while HALTED with simultaneous resume
    run_to_phase(4);
    @(negedge clk);
    check("pre-rst halted", 32'(halted), 32'd1);
    #1 rst = 1'b1; resume = 1'b1;
    @(negedge clk);
    check("rst halted phase", 32'(phase), 32'd0);
    check("rst halted flag", 32'(halted), 32'd0);
    check("rst halted sel", 32'(sel), 32'd1);
    #1 rst = 1'b0; resume = 1'b0; opcode = 4'd2;

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      rst     = ($urandom_range(0, 199) == 0);
      opcode  = 4'($urandom_range(0, 15));
      zero    = 1'($urandom_range(0, 1));
      mem_rdy = ($urandom_range(0, 3) != 0);
      resume  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/veririsc_sequencer.md
# veririsc_sequencer

Self-timed VeriRISC control unit that replaces the externally phased controller. It contains its own 8-phase fetch/execute counter, a halt/resume latch and an optional memory wait-state stall with timeout. It decodes a parametrised-width opcode into the same nine datapath strobes and sits between the instruction register, memory, PC and accumulator.

## Interface
- OPCODE_W, 3, opcode width (≥3); opcodes ≥ 8 form the extended-ALU class.
- WAIT_LIMIT, 15, maximum stall cycles per memory access before timeout (1–255); used only with the wait feature.

- clk  input  1  clock; every state element updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- zero  input  1  accumulator-is-zero flag.
- opcode  input  OPCODE_W  current instruction-register opcode.
- mem_rdy  input  1  memory read data valid.
- resume  input  1  leave HALTED (level sampled).
- phase  output  3  current phase 0–7.
- sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e  output  1 each  datapath strobes.
- halted  output  1  sequencer frozen by HLT.
- bus_err  output  1  one-cycle pulse on wait timeout.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALU class (ALUOP) = ADD, AND, XOR, LDA, or opcode ≥ 8.
- States: RUN, HALTED. In RUN, phase increments each cycle with wrap 7→0 unless stalled.
- Strobes are combinational from phase, state and inputs. All strobes are 0 in HALTED.
- Strobes by phase:
  - phase 0: sel.
  - phase 1: sel, rd.
  - phase 2: sel, rd, ld_ir.
  - phase 3: sel, rd, ld_ir.
  - phase 4: halt=(opcode==HLT), inc_pc.
  - phase 5: rd=ALUOP.
  - phase 6: rd=ALUOP, inc_pc=(SKZ&&zero), ld_pc=JMP, data_e=STO.
  - phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- HLT handling:
  - In phase 4 with opcode HLT, the next state is HALTED and phase holds at 4.
  - In HALTED, halted=1. When resume=1 is sampled, the next cycle is RUN at phase 5.
  - resume is ignored in RUN.
- Extended opcodes (≥8) with OPCODE_W>3 behave exactly as ALUOP. With OPCODE_W=3 the class is empty.

## Timing
- Reset: after the clk edge with rst=1, phase=0, state RUN, wait counter 0, bus_err=0, halted=0. Visible strobes are therefore sel=1, all others 0.
- rst dominates all events, including mid-stall, mid-HALTED and a simultaneous resume.
- Instruction cycle takes 8 clocks with no stalls. inc_pc is high for exactly one cycle in phase 4, plus phase 6 when a skip is taken.
- halt is combinational in phase 4. halted rises on the following cycle.
- A resume held high for many cycles exits HALTED once only. A HLT fetched after resume halts again.
- Stall points (feature enabled): phase 1 always, and phase 5 only when ALUOP.
  - If mem_rdy=0 at the edge, phase holds and the strobes of that phase stay asserted.
  - The wait counter increments each stalled cycle and clears when phase advances.
  - When the counter reaches WAIT_LIMIT, phase advances regardless. bus_err pulses for the one cycle after that edge.
  - A timeout is the phase advance itself; there is no separate extra stall cycle.
- Phase 5 with a non-ALU opcode never stalls. mem_rdy is don't-care outside stall points.

## Configuration
- SEQ_MEM_WAIT_EN defined:
  - mem_rdy stall logic, wait counter and bus_err are implemented.
- SEQ_MEM_WAIT_EN undefined:
  - mem_rdy is ignored and the phase never stalls.
  - bus_err is tied to 0 and WAIT_LIMIT is unused.
  - Cycle behaviour is identical to the feature-enabled build with mem_rdy held at 1.

## Test plan
- Reset, then free-run with ADD, zero=0, mem_rdy=1 → phases 0..7 repeat. Phase 7 shows rd=1, ld_ac=1; inc_pc is high only in phase 4.
- SKZ with zero=1 → inc_pc=1 in phases 4 and 6. With zero=0 → inc_pc=1 in phase 4 only. JMP → ld_pc=1 in phases 6 and 7. STO → data_e=1 in phases 6 and 7, wr=1 in phase 7, rd=0 throughout phases 5–7.
- HLT → halt=1 in phase 4, halted=1 with phase=4 for 10 cycles. resume pulse → phase=5 the next cycle, halted=0, and no second inc_pc.
- SEQ_MEM_WAIT_EN, mem_rdy=0 for 3 cycles at phase 1 → phase stays 1 for 4 cycles with sel=rd=1, then advances to 2. bus_err stays 0.
- SEQ_MEM_WAIT_EN, WAIT_LIMIT=4, mem_rdy stuck at 0, LDA → phase 5 held 4 cycles then advances to 6. bus_err pulses once.
- rst asserted while HALTED and while stalled in phase 5 → phase=0, halted=0, sel=1 on the next cycle.
